// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side burst master for the sync FIFO
// Pulls burst_len words into a 2-entry buffer and streams them out on m_data/m_valid/m_ready.
module fifo_rd_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic             fifo_underflow,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] rd_count,
  output logic             err_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic [1:0]       occ, occ_nx;
  logic [WIDTH-1:0] buf0, buf1;
  logic             push, pop;
  logic [2:0]       committed;

  // buf0 is always the head entry, so the stream data is a plain register
  assign m_data = buf0;
  assign pop    = m_valid && m_ready;
  assign push   = inflight && !fifo_underflow;
  assign busy   = (state == S_READ) || (state == S_DRAIN);
  assign done   = (state == S_DONE);

  // Slots already spoken for; a word leaving this cycle frees its slot for a new read
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (burst_len != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        fifo_rd_en = !abort && !fifo_empty && (remaining != '0) && (committed < 3'd2);
        if (abort || (fifo_rd_en && remaining == LEN_W'(1))) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (occ == 2'd0 && !inflight) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    occ_nx = occ;
    if (push && !pop)      occ_nx = occ + 2'd1;
    else if (!push && pop) occ_nx = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      m_valid       <= 1'b0;
      buf0          <= '0;
      buf1          <= '0;
      rd_count      <= '0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd_en;
      occ      <= occ_nx;
      m_valid  <= (occ_nx != 2'd0);

      if (state == S_IDLE && start) begin
        remaining     <= burst_len;
        rd_count      <= '0;
        err_underflow <= 1'b0;
      end else if (fifo_rd_en) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (pop) rd_count <= rd_count + LEN_W'(1);
      // A word returned with the underflow flag is garbage: drop it and remember
      if (inflight && fifo_underflow) err_underflow <= 1'b1;

      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data_out;
          else             buf1 <= fifo_data_out;
        end
        2'b01: buf0 <= buf1;
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_data_out;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
